dmem_access_ctrl: RTL

//  Sequences data-memory accesses for the instruction held in the EX/MEM pipeline register.

---
 rtl/dmem_access_ctrl.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/dmem_access_ctrl.sv
// Data-memory access sequencer for the EX/MEM instruction: turns MemRead/MemWrite into a
// req/ack handshake, stalls the pipeline until completion and records the first access error.
module dmem_access_ctrl #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 8
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              MemRead_i,
  input  logic              MemWrite_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic              mem_ack_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              stall_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic              rdata_valid_o,
  output logic              err_o,
  output logic [1:0]        err_code_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  state_e            state_q, state_d;
  logic [TO_W-1:0]   cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;
  logic [1:0]        err_code_q, err_code_d;
  logic              access_s;
  logic              aligned_s;

  assign access_s  = MemRead_i | MemWrite_i;
  assign aligned_s = (addr_i[1:0] == 2'b00);

  // State, latched request fields, load result and sticky error
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
      err_code_q <= 2'b00;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
    end
  end

  // Next-state logic; only the first error is ever recorded
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    err_code_d = err_code_q;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (access_s) begin
          if (aligned_s) begin
            addr_d  = addr_i;
            wdata_d = wdata_i;
            we_d    = MemWrite_i;
            state_d = S_BUSY;
            if (MemRead_i && MemWrite_i && !err_q) begin
              err_d      = 1'b1;
              err_code_d = 2'b11;
            end else begin
              err_d = err_q;
            end
          end else begin
            rdata_d = '0;
            state_d = S_DONE;
            if (!err_q) begin
              err_d      = 1'b1;
              err_code_d = 2'b01;
            end else begin
              err_d = err_q;
            end
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_BUSY: begin
        cnt_d = cnt_q + {{(TO_W-1){1'b0}}, 1'b1};
        if (mem_ack_i) begin
          if (!we_q) begin
            rdata_d = mem_rdata_i;
          end else begin
            rdata_d = rdata_q;
          end
          state_d = S_DONE;
        end else if (cnt_q == TO_LAST) begin
          rdata_d = '0;
          state_d = S_DONE;
          if (!err_q) begin
            err_d      = 1'b1;
            err_code_d = 2'b10;
          end else begin
            err_d = err_q;
          end
        end else begin
          state_d = S_BUSY;
        end
      end
      S_DONE: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs decode straight from registers so the request drops with reset
  assign mem_req_o     = (state_q == S_BUSY);
  assign mem_we_o      = we_q;
  assign mem_addr_o    = addr_q;
  assign mem_wdata_o   = wdata_q;
  assign stall_o       = rst_n_i & (((state_q == S_IDLE) & access_s) | (state_q == S_BUSY));
  assign rdata_o       = rdata_q;
  assign rdata_valid_o = (state_q == S_DONE);
  assign err_o         = err_q;
  assign err_code_o    = err_code_q;

endmodule
